// File: rtl/s2mm_cmd_generator_if.sv
// Command stream and status return channel between the S2MM command generator and the DataMover.
// The master side drives commands and consumes status strobes.
interface s2mm_cmd_generator_if;
    logic [71:0] m_axis_cmd_tdata;
    logic        m_axis_cmd_tvalid;
    logic        m_axis_cmd_tready;
    logic        sts_valid;
    logic        sts_ok;
    logic [3:0]  sts_tag;

    modport master (
        output m_axis_cmd_tdata,
        output m_axis_cmd_tvalid,
        input  m_axis_cmd_tready,
        input  sts_valid,
        input  sts_ok,
        input  sts_tag
    );

    modport slave (
        input  m_axis_cmd_tdata,
        input  m_axis_cmd_tvalid,
        output m_axis_cmd_tready,
        output sts_valid,
        output sts_ok,
        output sts_tag
    );
endinterface

// File: rtl/s2mm_cmd_generator.sv
// Splits a host transfer into tagged DataMover S2MM commands and tracks their status returns.
// Define S2MM_ERR_ABORT_EN to stop presenting new commands after the first error.
module s2mm_cmd_generator #(
    parameter int CHUNK_BYTES     = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         s_axi_clk,
    input  logic                         s_axi_resetn,
    input  logic                         start,
    input  logic [31:0]                  base_addr,
    input  logic [31:0]                  total_bytes,
    s2mm_cmd_generator_if.master         cmd_if,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [15:0]                  cmd_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_STS
    } state_t;

    localparam logic [31:0] CHUNK     = 32'(CHUNK_BYTES);
    localparam logic [22:0] CHUNK_BTT = 23'(CHUNK_BYTES);
    localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] remaining_q, remaining_d;
    logic [3:0]  tag_q, tag_d;
    logic [3:0]  exp_tag_q, exp_tag_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic [15:0] cmd_count_q, cmd_count_d;
    logic        error_q, error_d;
    logic        done_q, done_d;
    logic        tvalid_q, tvalid_d;
    logic [71:0] tdata_q, tdata_d;

    logic        hs;
    logic        sts_err;
    logic        sts_dec;
    logic        abort;
    logic        last_chunk;
    logic [22:0] chunk_btt;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        tag_d         = tag_q;
        exp_tag_d     = exp_tag_q;
        cmd_count_d   = cmd_count_q;
        error_d       = error_q;
        done_d        = 1'b0;
        tvalid_d      = tvalid_q;
        tdata_d       = tdata_q;
        sts_err       = 1'b0;
        sts_dec       = 1'b0;

        hs         = tvalid_q & cmd_if.m_axis_cmd_tready;
        last_chunk = (remaining_q <= CHUNK);
        chunk_btt  = last_chunk ? remaining_q[22:0] : CHUNK_BTT;

        // Statuses return in issue order, so the oldest outstanding tag is the only legal one.
        if (cmd_if.sts_valid) begin
            if (outstanding_q == 4'd0) begin
                sts_err = 1'b1;
            end else begin
                sts_dec   = 1'b1;
                exp_tag_d = exp_tag_q + 4'd1;
                if ((cmd_if.sts_tag != exp_tag_q) || !cmd_if.sts_ok) begin
                    sts_err = 1'b1;
                end
            end
        end
        if (sts_err) begin
            error_d = 1'b1;
        end
        outstanding_d = outstanding_q + {3'b000, hs} - {3'b000, sts_dec};

`ifdef S2MM_ERR_ABORT_EN
        abort = error_q | sts_err;
`else
        abort = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d     = 1'b0;
                    cmd_count_d = 16'd0;
                    tag_d       = 4'd0;
                    exp_tag_d   = 4'd0;
                    addr_d      = base_addr;
                    remaining_d = total_bytes;
                    if (total_bytes == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Always insert one idle cycle after a handshake before the next command.
                if (tvalid_q) begin
                    if (cmd_if.m_axis_cmd_tready) begin
                        tvalid_d    = 1'b0;
                        addr_d      = addr_q + {9'd0, tdata_q[22:0]};
                        remaining_d = remaining_q - {9'd0, tdata_q[22:0]};
                        tag_d       = tag_q + 4'd1;
                        if (cmd_count_q != 16'hFFFF) begin
                            cmd_count_d = cmd_count_q + 16'd1;
                        end
                        if (tdata_q[30]) begin
                            state_d = WAIT_STS;
                        end
                    end
                end else if (abort) begin
                    state_d = WAIT_STS;
                end else if (outstanding_q < MAX_OUT) begin
                    tvalid_d = 1'b1;
                    tdata_d  = {4'h0, tag_q, addr_q, 1'b0, last_chunk, 6'h00, 1'b1, chunk_btt};
                end
            end
            WAIT_STS: begin
                if (outstanding_q == 4'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            state_q       <= IDLE;
            addr_q        <= 32'd0;
            remaining_q   <= 32'd0;
            tag_q         <= 4'd0;
            exp_tag_q     <= 4'd0;
            outstanding_q <= 4'd0;
            cmd_count_q   <= 16'd0;
            error_q       <= 1'b0;
            done_q        <= 1'b0;
            tvalid_q      <= 1'b0;
            tdata_q       <= 72'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            tag_q         <= tag_d;
            exp_tag_q     <= exp_tag_d;
            outstanding_q <= outstanding_d;
            cmd_count_q   <= cmd_count_d;
            error_q       <= error_d;
            done_q        <= done_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
        end
    end

    assign cmd_if.m_axis_cmd_tdata  = tdata_q;
    assign cmd_if.m_axis_cmd_tvalid = tvalid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_s2mm_cmd_generator.sv
// Scoreboard bench for s2mm_cmd_generator: stimulus queues expected commands and done records,
// a negedge monitor compares them as the DUT presents handshakes and done pulses.
module tb_s2mm_cmd_generator;

    logic        s_axi_clk    = 1'b0;
    logic        s_axi_resetn = 1'b0;
    logic        start        = 1'b0;
    logic [31:0] base_addr    = 32'd0;
    logic [31:0] total_bytes  = 32'd0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] cmd_count;

    s2mm_cmd_generator_if cmd_if();

    s2mm_cmd_generator #(
        .CHUNK_BYTES    (4096),
        .MAX_OUTSTANDING(4)
    ) dut (
        .s_axi_clk   (s_axi_clk),
        .s_axi_resetn(s_axi_resetn),
        .start       (start),
        .base_addr   (base_addr),
        .total_bytes (total_bytes),
        .cmd_if      (cmd_if),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cmd_count   (cmd_count)
    );

    initial forever #5 s_axi_clk = ~s_axi_clk;

    int compared = 0;
    int failed   = 0;

    logic [71:0] exp_cmd[$];
    logic [16:0] exp_done[$];
    logic [4:0]  sts_fifo[$];

    int hs_count    = 0;
    int done_seen   = 0;
    int done_target = 0;
    int sts_sent    = 0;
    int sts_allow   = 1000000;
    int bad_tag_idx = -1;
    int bad_ok_idx  = -1;

    logic        mon_prev_valid = 1'b0;
    logic        mon_prev_hs    = 1'b0;
    logic [71:0] mon_prev_tdata = 72'd0;
    logic        mon_hs;
    logic [71:0] mon_exp;
    logic [16:0] mon_done_exp;

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge s_axi_clk);
        #1;
    endtask

    function automatic logic [71:0] mkCmd(input logic [31:0] addr, input logic [22:0] btt,
                                          input logic [3:0] tag, input logic eof);
        return {4'h0, tag, addr, 1'b0, eof, 6'h00, 1'b1, btt};
    endfunction

    // Full 4 KB commands followed by a final partial/full one carrying EOF.
    task automatic expectTransfer(input logic [31:0] base, input int n_cmds, input logic [22:0] last_btt);
        logic [31:0] a;
        a = base;
        for (int i = 0; i < n_cmds; i++) begin
            if (i == n_cmds - 1) exp_cmd.push_back(mkCmd(a, last_btt, 4'(i), 1'b1));
            else                 exp_cmd.push_back(mkCmd(a, 23'd4096, 4'(i), 1'b0));
            a = a + 32'h1000;
        end
    endtask

    task automatic expectDone(input logic err, input int cnt);
        exp_done.push_back({err, 16'(cnt)});
        done_target++;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] total);
        base_addr   = base;
        total_bytes = total;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic waitDone(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done_seen >= done_target) break;
            tick();
        end
        checkOutput(name, 72'(done_seen), 72'(done_target));
        repeat (3) tick();
    endtask

    task automatic waitValid(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (cmd_if.m_axis_cmd_tvalid) break;
            tick();
        end
        checkOutput(name, 72'(cmd_if.m_axis_cmd_tvalid), 72'(1));
    endtask

    // Monitor: checks handshakes, tdata stability and done pulses; queues statuses to return.
    initial begin
        forever begin
            @(negedge s_axi_clk);
            if (!s_axi_resetn) begin
                mon_prev_valid = 1'b0;
                mon_prev_hs    = 1'b0;
                continue;
            end
            mon_hs = cmd_if.m_axis_cmd_tvalid & cmd_if.m_axis_cmd_tready;
            if (mon_prev_valid && !mon_prev_hs && cmd_if.m_axis_cmd_tvalid)
                checkOutput("tdata_hold", cmd_if.m_axis_cmd_tdata, mon_prev_tdata);
            if (mon_hs) begin
                if (exp_cmd.size() == 0) begin
                    compared++;
                    failed++;
                    $display("[TB] FAIL cmd_unexpected: got tdata=%h, required no command",
                             cmd_if.m_axis_cmd_tdata);
                end else begin
                    mon_exp = exp_cmd.pop_front();
                    checkOutput("cmd_word", cmd_if.m_axis_cmd_tdata, mon_exp);
                end
                sts_fifo.push_back({(hs_count == bad_ok_idx) ? 1'b0 : 1'b1,
                                    (hs_count == bad_tag_idx) ? 4'd3 : cmd_if.m_axis_cmd_tdata[67:64]});
                hs_count++;
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    compared++;
                    failed++;
                    $display("[TB] FAIL done_unexpected: got done=1, required no done pulse");
                end else begin
                    mon_done_exp = exp_done.pop_front();
                    checkOutput("done_busy_err_count", 72'({busy, error, cmd_count}), 72'({1'b0, mon_done_exp}));
                end
                done_seen++;
            end
            mon_prev_valid = cmd_if.m_axis_cmd_tvalid;
            mon_prev_hs    = mon_hs;
            mon_prev_tdata = cmd_if.m_axis_cmd_tdata;
        end
    end

    // Status responder: returns one queued status per cycle while allowed.
    initial begin
        cmd_if.sts_valid = 1'b0;
        cmd_if.sts_ok    = 1'b0;
        cmd_if.sts_tag   = 4'd0;
        forever begin
            @(posedge s_axi_clk);
            #1;
            if (s_axi_resetn && sts_fifo.size() > 0 && sts_sent < sts_allow) begin
                {cmd_if.sts_ok, cmd_if.sts_tag} = sts_fifo.pop_front();
                cmd_if.sts_valid = 1'b1;
                sts_sent++;
            end else begin
                cmd_if.sts_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hs0;
        int n_err;
        cmd_if.m_axis_cmd_tready = 1'b1;
        repeat (3) tick();
        s_axi_resetn = 1'b1;
        tick();

        // Reset state
        checkOutput("rst_tvalid", 72'(cmd_if.m_axis_cmd_tvalid), 72'(0));
        checkOutput("rst_tdata", cmd_if.m_axis_cmd_tdata, 72'(0));
        checkOutput("rst_busy", 72'(busy), 72'(0));
        checkOutput("rst_done", 72'(done), 72'(0));
        checkOutput("rst_error", 72'(error), 72'(0));
        checkOutput("rst_cmd_count", 72'(cmd_count), 72'(0));

        // Basic 10000-byte transfer; a start while busy must be ignored
        exp_cmd.push_back(mkCmd(32'h1000_0000, 23'd4096, 4'd0, 1'b0));
        exp_cmd.push_back(mkCmd(32'h1000_1000, 23'd4096, 4'd1, 1'b0));
        exp_cmd.push_back(mkCmd(32'h1000_2000, 23'd1808, 4'd2, 1'b1));
        expectDone(1'b0, 3);
        applyStimulus(32'h1000_0000, 32'd10000);
        checkOutput("busy_after_start", 72'(busy), 72'(1));
        repeat (3) tick();
        applyStimulus(32'h5555_0000, 32'd4);
        waitDone("basic_done", 200);

        // Backpressure: tready low for 5 cycles with cmd 1 presented
        cmd_if.m_axis_cmd_tready = 1'b0;
        expectTransfer(32'h2000_0000, 3, 23'd1808);
        expectDone(1'b0, 3);
        applyStimulus(32'h2000_0000, 32'd10000);
        waitValid("stall_tvalid_rise", 20);
        repeat (5) tick();
        checkOutput("stall_tvalid_held", 72'(cmd_if.m_axis_cmd_tvalid), 72'(1));
        checkOutput("stall_no_handshake", 72'(cmd_count), 72'(0));
        cmd_if.m_axis_cmd_tready = 1'b1;
        waitDone("stall_done", 200);

        // Outstanding limit: no statuses -> exactly 4 commands, one status -> 5th
        sts_allow = sts_sent;
        hs0 = hs_count;
        expectTransfer(32'h3000_0000, 8, 23'd4096);
        expectDone(1'b0, 8);
        applyStimulus(32'h3000_0000, 32'd32768);
        repeat (40) tick();
        checkOutput("limit_four_cmds", 72'(hs_count - hs0), 72'(4));
        checkOutput("limit_tvalid_low", 72'(cmd_if.m_axis_cmd_tvalid), 72'(0));
        sts_allow = sts_sent + 1;
        repeat (10) tick();
        checkOutput("limit_fifth_cmd", 72'(hs_count - hs0), 72'(5));
        sts_allow = 1000000;
        waitDone("limit_done", 300);

        // 17 commands: tag wraps 15->0 and address wraps past 2^32
        expectTransfer(32'hFFFF_8000, 17, 23'd4096);
        expectDone(1'b0, 17);
        applyStimulus(32'hFFFF_8000, 32'd69632);
        waitDone("wrap_done", 400);

`ifdef S2MM_ERR_ABORT_EN
        n_err = 1;
`else
        n_err = 3;
`endif
        // Wrong tag on the first status
        bad_tag_idx = hs_count;
        expectTransfer(32'h4000_0000, 3, 23'd4096);
        for (int i = 0; i < 3 - n_err; i++) void'(exp_cmd.pop_back());
        expectDone(1'b1, n_err);
        applyStimulus(32'h4000_0000, 32'd12288);
        waitDone("bad_tag_done", 200);
        checkOutput("bad_tag_error", 72'(error), 72'(1));
        bad_tag_idx = -1;

        // Error status on the first command
        bad_ok_idx = hs_count;
        expectTransfer(32'h4000_0000, 3, 23'd4096);
        for (int i = 0; i < 3 - n_err; i++) void'(exp_cmd.pop_back());
        expectDone(1'b1, n_err);
        applyStimulus(32'h4000_0000, 32'd12288);
        waitDone("bad_ok_done", 200);
        checkOutput("bad_ok_error", 72'(error), 72'(1));
        bad_ok_idx = -1;

        // Zero-length transfer clears error and pulses done one cycle later
        expectDone(1'b0, 0);
        applyStimulus(32'h6000_0000, 32'd0);
        checkOutput("zero_done", 72'(done), 72'(1));
        checkOutput("zero_busy", 72'(busy), 72'(0));
        checkOutput("zero_error_cleared", 72'(error), 72'(0));
        tick();
        checkOutput("zero_done_pulse", 72'(done), 72'(0));
        waitDone("zero_done_seen", 10);

        // Reset in the middle of ISSUE
        cmd_if.m_axis_cmd_tready = 1'b0;
        expectTransfer(32'h7000_0000, 3, 23'd1808);
        applyStimulus(32'h7000_0000, 32'd10000);
        waitValid("midrst_tvalid_rise", 20);
        #2;
        s_axi_resetn = 1'b0;
        #1;
        checkOutput("midrst_tvalid", 72'(cmd_if.m_axis_cmd_tvalid), 72'(0));
        checkOutput("midrst_tdata", cmd_if.m_axis_cmd_tdata, 72'(0));
        checkOutput("midrst_busy", 72'(busy), 72'(0));
        checkOutput("midrst_cmd_count", 72'(cmd_count), 72'(0));
        exp_cmd.delete();
        repeat (2) tick();
        s_axi_resetn = 1'b1;
        cmd_if.m_axis_cmd_tready = 1'b1;
        repeat (5) tick();
        checkOutput("postrst_idle_tvalid", 72'(cmd_if.m_axis_cmd_tvalid), 72'(0));

        checkOutput("cmd_queue_drained", 72'(exp_cmd.size()), 72'(0));
        checkOutput("done_queue_drained", 72'(exp_done.size()), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
